// File: rtl/dual_rank_pkg.sv
// Shared types and constants for the two-rank request front-end.
package dual_rank_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 8;
  localparam int unsigned DEF_WORDADDR_WIDTH = 7;
  localparam int unsigned DEF_DATA_WIDTH     = 8;

  localparam logic RANK0 = 1'b0;
  localparam logic RANK1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dual_rank_ctrl.sv
// Request front-end for two 128x8 RAM ranks: decodes the address MSB to a
// rank, inserts a one-cycle turnaround on rank switches, pulses one chip
// select per request and returns read data over a valid/ready channel.
module dual_rank_ctrl
  import dual_rank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned WORDADDR_WIDTH = DEF_WORDADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_wr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [WORDADDR_WIDTH-1:0] rank_addr,
  output logic                      rank_wr,
  output logic [DATA_WIDTH-1:0]     rank_din,
  output logic                      rank0_cs,
  output logic                      rank1_cs,
  input  logic [DATA_WIDTH-1:0]     rank0_dout,
  input  logic [DATA_WIDTH-1:0]     rank1_dout,
  output logic                      busy
);

  state_t                    state_q, state_d;
  logic [WORDADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      rank_q, rank_d;
  logic                      last_rank_q, last_rank_d;
  logic                      last_rank_vld_q, last_rank_vld_d;
  logic [WORDADDR_WIDTH-1:0] rank_addr_q, rank_addr_d;
  logic [DATA_WIDTH-1:0]     rank_din_q, rank_din_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                      req_rank;

  assign req_rank = req_addr[ADDR_WIDTH-1];

  // Next-state and datapath register updates.
  // The shared bus registers load only on the transition into ACCESS, so
  // they keep their previous contents through IDLE and TURN.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wr_d            = wr_q;
    wdata_d         = wdata_q;
    rank_d          = rank_q;
    last_rank_d     = last_rank_q;
    last_rank_vld_d = last_rank_vld_q;
    rank_addr_d     = rank_addr_q;
    rank_din_d      = rank_din_q;
    rsp_rdata_d     = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[WORDADDR_WIDTH-1:0];
          wr_d    = req_wr;
          wdata_d = req_wdata;
          rank_d  = req_rank;
          if (last_rank_vld_q && (req_rank != last_rank_q)) begin
            state_d = ST_TURN;
          end else begin
            state_d     = ST_ACCESS;
            rank_addr_d = req_addr[WORDADDR_WIDTH-1:0];
            rank_din_d  = req_wdata;
          end
        end
      end
      ST_TURN: begin
        state_d     = ST_ACCESS;
        rank_addr_d = addr_q;
        rank_din_d  = wdata_q;
      end
      ST_ACCESS: begin
        last_rank_d     = rank_q;
        last_rank_vld_d = 1'b1;
        state_d         = wr_q ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rsp_rdata_d = (rank_q == RANK1) ? rank1_dout : rank0_dout;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      wr_q            <= 1'b0;
      wdata_q         <= '0;
      rank_q          <= RANK0;
      last_rank_q     <= RANK0;
      last_rank_vld_q <= 1'b0;
      rank_addr_q     <= '0;
      rank_din_q      <= '0;
      rsp_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wr_q            <= wr_d;
      wdata_q         <= wdata_d;
      rank_q          <= rank_d;
      last_rank_q     <= last_rank_d;
      last_rank_vld_q <= last_rank_vld_d;
      rank_addr_q     <= rank_addr_d;
      rank_din_q      <= rank_din_d;
      rsp_rdata_q     <= rsp_rdata_d;
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !rst;
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rsp_rdata_q;
    rank0_cs  = (state_q == ST_ACCESS) && (rank_q == RANK0);
    rank1_cs  = (state_q == ST_ACCESS) && (rank_q == RANK1);
    rank_wr   = (state_q == ST_ACCESS) && wr_q;
    rank_addr = rank_addr_q;
    rank_din  = rank_din_q;
  end

endmodule

// File: tb/tb_dual_rank_ctrl.sv
// Directed bench for dual_rank_ctrl with two behavioural 128x8 RAM ranks.
module tb_dual_rank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic       req_wr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [6:0] rank_addr;
  logic       rank_wr;
  logic [7:0] rank_din;
  logic       rank0_cs;
  logic       rank1_cs;
  logic [7:0] rank0_dout;
  logic [7:0] rank1_dout;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int c0_cnt = 0;
  int c1_cnt = 0;
  int both_cnt = 0;

  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];

  always #5 clk = ~clk;

  dual_rank_ctrl #(
    .ADDR_WIDTH(8),
    .WORDADDR_WIDTH(7),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rank_addr(rank_addr), .rank_wr(rank_wr), .rank_din(rank_din),
    .rank0_cs(rank0_cs), .rank1_cs(rank1_cs),
    .rank0_dout(rank0_dout), .rank1_dout(rank1_dout),
    .busy(busy)
  );

  // Behavioural RAM ranks: read data registered on cs & !wr.
  initial begin
    for (int i = 0; i < 128; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    rank0_dout = 8'h00;
    rank1_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (rank0_cs) begin
      c0_cnt++;
      if (rank_wr) mem0[rank_addr] <= rank_din;
      else rank0_dout <= mem0[rank_addr];
    end
    if (rank1_cs) begin
      c1_cnt++;
      if (rank_wr) mem1[rank_addr] <= rank_din;
      else rank1_dout <= mem1[rank_addr];
    end
    if (rank0_cs && rank1_cs) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one cycle after its acceptance edge.
  task automatic issue(input logic [7:0] a, input logic w, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wr    = w;
    req_wdata = d;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout addr=%h got req_ready=%b want 1", a, req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns the cycle rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 8'h85;
    req_wr    = 1'b1;
    req_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
          rank0_cs !== 1'b0 || rank1_cs !== 1'b0 || rank_wr !== 1'b0 ||
          rank_addr !== 7'h00 || rank_din !== 8'h00 || rsp_rdata !== 8'h00) begin
        errors++;
        $display("FAIL reset_values rdy=%b busy=%b vld=%b cs=%b%b wr=%b addr=%h din=%h rd=%h want all 0",
                 req_ready, busy, rsp_valid, rank1_cs, rank0_cs, rank_wr, rank_addr, rank_din, rsp_rdata);
      end
    end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", req_ready);
    end
    checks++;
    if (c0_cnt !== 0 || c1_cnt !== 0) begin
      errors++;
      $display("FAIL reset_req_ignored cs0=%0d cs1=%0d want 0 0", c0_cnt, c1_cnt);
    end
  endtask

  task automatic test_same_rank();
    int lat;
    c0_cnt = 0;
    c1_cnt = 0;
    issue(8'h05, 1'b1, 8'hA5);
    checks++;
    if (rank0_cs !== 1'b1 || rank1_cs !== 1'b0 || rank_wr !== 1'b1 ||
        rank_addr !== 7'h05 || rank_din !== 8'hA5) begin
      errors++;
      $display("FAIL wr_access cs=%b%b wr=%b addr=%h din=%h want 01 1 05 a5",
               rank1_cs, rank0_cs, rank_wr, rank_addr, rank_din);
    end
    step();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_back_idle rdy=%b busy=%b want 1 0", req_ready, busy);
    end
    issue(8'h05, 1'b0, 8'h00);
    checks++;
    if (rank0_cs !== 1'b1 || rank_wr !== 1'b0) begin
      errors++;
      $display("FAIL rd_access cs0=%b wr=%b want 1 0", rank0_cs, rank_wr);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rd_latency_same got %0d want 3", lat);
    end
    checks++;
    if (rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data_same got %h want a5", rsp_rdata);
    end
    consume();
    checks++;
    if (c0_cnt != 2 || c1_cnt != 0) begin
      errors++;
      $display("FAIL cs_pulse_count cs0=%0d cs1=%0d want 2 0", c0_cnt, c1_cnt);
    end
  endtask

  task automatic test_rank_switch();
    int lat;
    issue(8'h85, 1'b1, 8'h3C);
    checks++;
    if (rank0_cs !== 1'b0 || rank1_cs !== 1'b0 || busy !== 1'b1 || rank_din !== 8'h00) begin
      errors++;
      $display("FAIL turn_cycle cs=%b%b busy=%b din=%h want 00 1 00",
               rank1_cs, rank0_cs, busy, rank_din);
    end
    step();
    checks++;
    if (rank1_cs !== 1'b1 || rank0_cs !== 1'b0 || rank_wr !== 1'b1 ||
        rank_addr !== 7'h05 || rank_din !== 8'h3C) begin
      errors++;
      $display("FAIL switch_wr_access cs=%b%b wr=%b addr=%h din=%h want 10 1 05 3c",
               rank1_cs, rank0_cs, rank_wr, rank_addr, rank_din);
    end
    step();
    issue(8'h05, 1'b0, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL rd_latency_switch got %0d want 4", lat);
    end
    checks++;
    if (rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data_switch got %h want a5", rsp_rdata);
    end
    consume();
    checks++;
    if (mem1[5] !== 8'h3C) begin
      errors++;
      $display("FAIL rank1_word5 got %h want 3c", mem1[5]);
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n = 0;
    logic accepted;
    logic [7:0] addrs [3];
    logic [7:0] datas [3];
    addrs[0] = 8'h01; addrs[1] = 8'h02; addrs[2] = 8'h03;
    datas[0] = 8'h11; datas[1] = 8'h22; datas[2] = 8'h33;
    for (int i = 0; i < 3; i++) acc[i] = -1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = addrs[0];
    req_wdata = datas[0];
    for (int cyc = 0; n < 3 && cyc < 20; cyc++) begin
      accepted = req_ready;
      step();
      if (accepted) begin
        acc[n] = cyc;
        n++;
        if (n < 3) begin
          req_addr  = addrs[n];
          req_wdata = datas[n];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i] != 2 * i) begin
        errors++;
        $display("FAIL b2b_accept_cycle idx=%0d got %0d want %0d", i, acc[i], 2 * i);
      end
    end
    checks++;
    if (rank0_cs !== 1'b1 || rank_addr !== 7'h03 || rank_din !== 8'h33) begin
      errors++;
      $display("FAIL b2b_last_access cs0=%b addr=%h din=%h want 1 03 33",
               rank0_cs, rank_addr, rank_din);
    end
    step();
    checks++;
    if (mem0[2] !== 8'h22) begin
      errors++;
      $display("FAIL b2b_mem_word2 got %h want 22", mem0[2]);
    end
  endtask

  task automatic test_rsp_hold();
    int lat;
    issue(8'h02, 1'b0, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL hold_latency got %0d want 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h22 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d vld=%b rd=%h rdy=%b want 1 22 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      step();
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release vld=%b busy=%b rdy=%b want 0 0 1", rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int c0s, c1s;
    logic seen = 1'b0;
    issue(8'h03, 1'b0, 8'h00);
    step();
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || rank0_cs !== 1'b0) begin
      errors++;
      $display("FAIL capture_state busy=%b vld=%b cs0=%b want 1 0 0", busy, rsp_valid, rank0_cs);
    end
    rst = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
        rank0_cs !== 1'b0 || rank1_cs !== 1'b0 || rank_wr !== 1'b0 ||
        rank_addr !== 7'h00 || rank_din !== 8'h00 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_values rdy=%b busy=%b vld=%b cs=%b%b wr=%b addr=%h din=%h rd=%h want all 0",
               req_ready, busy, rsp_valid, rank1_cs, rank0_cs, rank_wr, rank_addr, rank_din, rsp_rdata);
    end
    rst = 1'b0;
    c0s = c0_cnt;
    c1s = c1_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || c0_cnt != c0s || c1_cnt != c1s) begin
      errors++;
      $display("FAIL mid_reset_dropped rsp_seen=%b cs0_delta=%0d cs1_delta=%0d want 0 0 0",
               seen, c0_cnt - c0s, c1_cnt - c1s);
    end
    issue(8'h90, 1'b1, 8'h77);
    checks++;
    if (rank1_cs !== 1'b1 || rank_addr !== 7'h10) begin
      errors++;
      $display("FAIL post_reset_no_turn cs1=%b addr=%h want 1 10", rank1_cs, rank_addr);
    end
    step();
  endtask

  task automatic test_wrap();
    int lat;
    issue(8'h7F, 1'b1, 8'h5A);
    checks++;
    if (rank0_cs !== 1'b0 || rank1_cs !== 1'b0) begin
      errors++;
      $display("FAIL wrap_turn0 cs=%b%b want 00", rank1_cs, rank0_cs);
    end
    step();
    checks++;
    if (rank0_cs !== 1'b1 || rank_addr !== 7'h7F) begin
      errors++;
      $display("FAIL wrap_wr_7f cs0=%b addr=%h want 1 7f", rank0_cs, rank_addr);
    end
    step();
    issue(8'hFF, 1'b1, 8'hC3);
    step();
    checks++;
    if (rank1_cs !== 1'b1 || rank0_cs !== 1'b0 || rank_addr !== 7'h7F) begin
      errors++;
      $display("FAIL wrap_wr_ff cs=%b%b addr=%h want 10 7f", rank1_cs, rank0_cs, rank_addr);
    end
    step();
    issue(8'hFF, 1'b0, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL wrap_rd_ff lat=%0d rd=%h want 3 c3", lat, rsp_rdata);
    end
    consume();
    issue(8'h7F, 1'b0, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 4 || rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_rd_7f lat=%0d rd=%h want 4 5a", lat, rsp_rdata);
    end
    consume();
  endtask

  task automatic test_cs_exclusive();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL cs_exclusive both_high_cycles=%0d want 0", both_cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 8'h00;
    req_wr    = 1'b0;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;
    test_reset();
    test_same_rank();
    test_rank_switch();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    test_wrap();
    test_cs_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
